// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - reset/run sequencer for the MIPS core harness
//
// Holds the core in reset for HOLD_CYCLES after controller reset, then counts
// RUN cycles and retired instructions until a halt (halt PC or self-loop) or a
// cycle-budget timeout. Both terminal states are sticky until restart/reset.
//
// Ports:
//   clk        in  rising-edge clock
//   reset      in  asynchronous active-low controller reset
//   restart    in  synchronous pulse, back to HOLD from any state
//   retire     in  core retired one instruction this cycle
//   retire_pc  in  PC of the retired instruction
//   cpu_reset  out active-high reset to the core (high in HOLD)
//   running    out high in RUN
//   done       out high in HALTED
//   timeout    out high in TIMEOUT
//   cycle_cnt  out RUN cycles elapsed
//   retire_cnt out instructions retired in RUN
module mips_run_ctrl #(
   parameter int          HOLD_CYCLES = 50,
   parameter int          CNT_W       = 32,
   parameter int unsigned MAX_CYCLES  = 100000,
   parameter logic [31:0] HALT_PC     = 32'h0000_4ffc,
   parameter int          HALT_REPEAT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic             retire,
   input  logic [31:0]      retire_pc,
   output logic             cpu_reset,
   output logic             running,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int RW = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT + 1) : 1;

   localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
   localparam logic [RW-1:0]    REP_ONE   = RW'(1);
   localparam logic [RW-1:0]    REP_LIMIT = RW'(HALT_REPEAT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {
      S_HOLD,
      S_RUN,
      S_HALTED,
      S_TIMEOUT
   } state_t;

   state_t           state, state_nxt;
   logic [HW-1:0]    hold_cnt, hold_nxt;
   logic [RW-1:0]    rep_cnt, rep_nxt, rep_upd;
   logic [31:0]      last_pc, last_pc_nxt;
   logic [CNT_W-1:0] cyc_nxt, ret_nxt;
   logic             halt_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_ONE;
   endfunction

   // Repeat count this retire would produce: a PC change restarts the run of
   // identical PCs at 1.
   always_comb begin
      rep_upd = REP_ONE;
      if (retire_pc == last_pc) begin
         rep_upd = (rep_cnt == '1) ? rep_cnt : rep_cnt + REP_ONE;
      end
   end

   always_comb begin
      halt_hit = 1'b0;
      if (retire) begin
         halt_hit = (retire_pc == HALT_PC) ||
                    ((HALT_REPEAT != 0) && (rep_upd >= REP_LIMIT));
      end
   end

   always_comb begin
      state_nxt   = state;
      hold_nxt    = hold_cnt;
      rep_nxt     = rep_cnt;
      last_pc_nxt = last_pc;
      cyc_nxt     = cycle_cnt;
      ret_nxt     = retire_cnt;

      if (restart) begin
         // Counters keep their values until the next RUN entry.
         state_nxt = S_HOLD;
         hold_nxt  = '0;
      end else begin
         case (state)
            S_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state_nxt = S_RUN;
                  cyc_nxt   = '0;
                  ret_nxt   = '0;
                  rep_nxt   = '0;
               end else begin
                  hold_nxt = hold_cnt + HOLD_ONE;
               end
            end
            S_RUN: begin
               cyc_nxt = sat_inc(cycle_cnt);
               if (retire) begin
                  ret_nxt     = sat_inc(retire_cnt);
                  rep_nxt     = rep_upd;
                  last_pc_nxt = retire_pc;
               end
               // Halt wins over a timeout in the same cycle.
               if (halt_hit) begin
                  state_nxt = S_HALTED;
               end else if (cycle_cnt == CYC_LAST) begin
                  state_nxt = S_TIMEOUT;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_HOLD;
         hold_cnt   <= '0;
         rep_cnt    <= '0;
         last_pc    <= '0;
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         cpu_reset  <= 1'b1;
         running    <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_nxt;
         rep_cnt    <= rep_nxt;
         last_pc    <= last_pc_nxt;
         cycle_cnt  <= cyc_nxt;
         retire_cnt <= ret_nxt;
         // Flags are decoded from the next state so they line up with it.
         cpu_reset  <= (state_nxt == S_HOLD);
         running    <= (state_nxt == S_RUN);
         done       <= (state_nxt == S_HALTED);
         timeout    <= (state_nxt == S_TIMEOUT);
      end
   end

endmodule
